// File: rtl/stack_cpu_driver.sv
// stack_cpu_driver
//   Feeds a nibble-serial stack CPU from a small on-chip program memory.
//   The program is a stream of opcode nibbles, each optionally followed by
//   one operand nibble (opcodes 1, 6, 7, 8). Opcode F halts the driver and is
//   never forwarded. Running off the end of memory ends the program after
//   the instruction that crossed address 15 has executed in full.
//
// Ports
//   clk        in   single clock, rising edge
//   rst        in   asynchronous, active-high reset
//   prog_we    in   program-memory write strobe (ignored while busy)
//   prog_addr  in   [3:0] program-memory write address
//   prog_data  in   [3:0] program-memory write nibble
//   start      in   run request, sampled only while idle
//   cpu_inbits out  [3:0] instruction/operand nibble to the CPU
//   cpu_rst    out  reset to the CPU (held high while the driver is reset)
//   busy       out  high from start acceptance through the DONE cycle
//   done       out  one-cycle completion pulse
module stack_cpu_driver #(
  parameter int unsigned MEM_DEPTH = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       prog_we,
  input  logic [3:0] prog_addr,
  input  logic [3:0] prog_data,
  input  logic       start,
  output logic [3:0] cpu_inbits,
  output logic       cpu_rst,
  output logic       busy,
  output logic       done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CPURST,
    S_FETCH,
    S_EXEC,
    S_DONE
  } state_t;

  localparam logic [3:0] OP_HALT = 4'hF;

  state_t     state, state_n;
  logic [3:0] pc, pc_n;
  logic       wrap, wrap_n;
  logic [1:0] count, count_n;
  logic [3:0] opcode, opcode_n;
  logic [3:0] operand, operand_n;
  logic [3:0] inbits_n;
  logic       cpu_rst_n, busy_n, done_n;

  logic [3:0] mem [MEM_DEPTH];

  logic [3:0] fetch_op;
  logic [3:0] next_nibble;
  logic [4:0] pc_sum;

  // Opcodes that consume the following nibble as an operand.
  function automatic logic has_operand(input logic [3:0] op);
    case (op)
      4'h1, 4'h6, 4'h7, 4'h8: has_operand = 1'b1;
      default:                has_operand = 1'b0;
    endcase
  endfunction

  // Number of EXEC cycles the CPU needs for each opcode.
  function automatic logic [1:0] exec_count(input logic [3:0] op);
    case (op)
      4'h1, 4'h2, 4'h5, 4'h6, 4'h7, 4'h8: exec_count = 2'd2;
      4'h9, 4'hA, 4'hC, 4'hD:             exec_count = 2'd3;
      default:                            exec_count = 2'd1;
    endcase
  endfunction

  // Program memory is not reset; writes are accepted only while idle.
  always_ff @(posedge clk) begin
    if (prog_we && !busy)
      mem[prog_addr] <= prog_data;
  end

  assign fetch_op    = mem[pc];
  assign next_nibble = mem[pc + 4'd1];   // 4-bit wrap: operand of addr 15 is addr 0
  assign pc_sum      = {1'b0, pc} + (has_operand(fetch_op) ? 5'd2 : 5'd1);

  // Outputs are registered, so this block computes the output values that
  // belong to the state being entered, alongside the next state itself.
  always_comb begin
    state_n   = state;
    pc_n      = pc;
    wrap_n    = wrap;
    count_n   = count;
    opcode_n  = opcode;
    operand_n = operand;
    inbits_n  = '0;
    cpu_rst_n = 1'b0;
    busy_n    = 1'b1;
    done_n    = 1'b0;

    case (state)
      S_IDLE: begin
        busy_n = 1'b0;
        if (start) begin
          state_n   = S_CPURST;
          pc_n      = '0;
          wrap_n    = 1'b0;
          cpu_rst_n = 1'b1;
          busy_n    = 1'b1;
        end
      end

      S_CPURST: begin
        state_n  = S_FETCH;
        inbits_n = (fetch_op == OP_HALT) ? 4'h0 : fetch_op;
      end

      S_FETCH: begin
        if (fetch_op == OP_HALT) begin
          state_n = S_DONE;
          done_n  = 1'b1;
        end else begin
          state_n   = S_EXEC;
          opcode_n  = fetch_op;
          operand_n = next_nibble;
          count_n   = exec_count(fetch_op);
          pc_n      = pc_sum[3:0];
          if (pc_sum[4])
            wrap_n = 1'b1;
          inbits_n  = has_operand(fetch_op) ? next_nibble : 4'h0;
        end
      end

      S_EXEC: begin
        count_n = count - 2'd1;
        if (count <= 2'd1) begin
          if (wrap) begin
            state_n = S_DONE;
            done_n  = 1'b1;
          end else begin
            // pc already points at the next opcode, so the FETCH nibble is
            // presented on the same edge that leaves EXEC.
            state_n  = S_FETCH;
            inbits_n = (fetch_op == OP_HALT) ? 4'h0 : fetch_op;
          end
        end else begin
          inbits_n = has_operand(opcode) ? operand : 4'h0;
        end
      end

      S_DONE: begin
        state_n = S_IDLE;
        busy_n  = 1'b0;
      end

      default: begin
        state_n = S_IDLE;
        busy_n  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      pc         <= '0;
      wrap       <= 1'b0;
      count      <= '0;
      opcode     <= '0;
      operand    <= '0;
      cpu_inbits <= '0;
      cpu_rst    <= 1'b1;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      state      <= state_n;
      pc         <= pc_n;
      wrap       <= wrap_n;
      count      <= count_n;
      opcode     <= opcode_n;
      operand    <= operand_n;
      cpu_inbits <= inbits_n;
      cpu_rst    <= cpu_rst_n;
      busy       <= busy_n;
      done       <= done_n;
    end
  end

endmodule

// File: tb/tb_stack_cpu_driver.sv
// Testbench for stack_cpu_driver: directed programs plus random programs,
// each checked cycle by cycle against a behavioural trace model.
module tb_stack_cpu_driver;

  logic       clk = 1'b0;
  logic       rst;
  logic       prog_we;
  logic [3:0] prog_addr;
  logic [3:0] prog_data;
  logic       start;
  logic [3:0] cpu_inbits;
  logic       cpu_rst;
  logic       busy;
  logic       done;

  int n_cmp = 0;
  int n_bad = 0;

  logic [3:0] img [16];          // program image to load
  logic [6:0] exp_q [$];         // expected {cpu_rst,busy,done,inbits} per cycle

  stack_cpu_driver #(.MEM_DEPTH(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .prog_we    (prog_we),
    .prog_addr  (prog_addr),
    .prog_data  (prog_data),
    .start      (start),
    .cpu_inbits (cpu_inbits),
    .cpu_rst    (cpu_rst),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] pk(input logic r, input logic b, input logic d,
                                    input logic [3:0] n);
    return {r, b, d, n};
  endfunction

  function automatic logic [6:0] obs();
    return {cpu_rst, busy, done, cpu_inbits};
  endfunction

  // Expected cycle-by-cycle bus trace from start acceptance to the IDLE cycle
  // after DONE, derived from the program-stream rules.
  function automatic void build_trace();
    int pc;
    int cnt;
    int step;
    bit wrapped;
    logic [3:0] op;
    logic [3:0] opnd;
    bit takes;
    exp_q.delete();
    exp_q.push_back(pk(1'b1, 1'b1, 1'b0, 4'h0));
    pc = 0;
    wrapped = 0;
    while (1) begin
      op = img[pc];
      if (op == 4'hF) begin
        exp_q.push_back(pk(1'b0, 1'b1, 1'b0, 4'h0));
        break;
      end
      exp_q.push_back(pk(1'b0, 1'b1, 1'b0, op));
      takes = (op == 4'h1) || (op == 4'h6) || (op == 4'h7) || (op == 4'h8);
      case (op)
        4'h0, 4'h3, 4'h4, 4'hB, 4'hE: cnt = 1;
        4'h9, 4'hA, 4'hC, 4'hD:       cnt = 3;
        default:                      cnt = 2;
      endcase
      opnd = takes ? img[(pc + 1) % 16] : 4'h0;
      for (int k = 0; k < cnt; k++)
        exp_q.push_back(pk(1'b0, 1'b1, 1'b0, opnd));
      step = takes ? 2 : 1;
      if (pc + step > 15)
        wrapped = 1;
      pc = (pc + step) % 16;
      if (wrapped)
        break;
    end
    exp_q.push_back(pk(1'b0, 1'b1, 1'b1, 4'h0));
    exp_q.push_back(pk(1'b0, 1'b0, 1'b0, 4'h0));
  endfunction

  task automatic chk(input string tag, input int cyc, input logic [6:0] o,
                     input logic [6:0] e);
    n_cmp++;
    assert (o === e) else begin
      n_bad++;
      $error("FAIL %s cyc %0d: got {rst,busy,done,bits}=%b want %b", tag, cyc, o, e);
    end
  endtask

  task automatic chk_int(input string tag, input int o, input int e);
    n_cmp++;
    assert (o === e) else begin
      n_bad++;
      $error("FAIL %s: got %0d want %0d", tag, o, e);
    end
  endtask

  task automatic load();
    for (int a = 0; a < 16; a++) begin
      @(negedge clk);
      prog_we   = 1'b1;
      prog_addr = 4'(a);
      prog_data = img[a];
    end
    @(negedge clk);
    prog_we = 1'b0;
  endtask

  // Runs the loaded program and checks every cycle. At cycle index inj (if
  // >= 0) a write and a start request are injected while the driver is busy.
  task automatic run(input string tag, input int inj,
                     output int busy_cyc, output int done_idx);
    logic [6:0] o;
    build_trace();
    busy_cyc = 0;
    done_idx = -1;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < exp_q.size(); i++) begin
      o = obs();
      chk(tag, i, o, exp_q[i]);
      if (o[5]) busy_cyc++;
      if (o[4] && done_idx < 0) done_idx = i;
      if (i == inj) begin
        start     = 1'b1;
        prog_we   = 1'b1;
        prog_addr = 4'(i);
        prog_data = ~img[i];
      end else begin
        start   = 1'b0;
        prog_we = 1'b0;
      end
      @(negedge clk);
    end
    start   = 1'b0;
    prog_we = 1'b0;
  endtask

  initial begin
    int bc;
    int di;
    rst       = 1'b1;
    prog_we   = 1'b0;
    prog_addr = '0;
    prog_data = '0;
    start     = 1'b0;

    // Reset values before any clock edge, then release.
    #3;
    chk("reset_async", 0, obs(), pk(1'b1, 1'b0, 1'b0, 4'h0));
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("reset_held", 0, obs(), pk(1'b1, 1'b0, 1'b0, 4'h0));
    @(negedge clk);
    chk("reset_release", 0, obs(), pk(1'b0, 1'b0, 1'b0, 4'h0));

    // Basic program with operands and HALT.
    img = '{4'h1, 4'h5, 4'h1, 4'h3, 4'h8, 4'h0, 4'h3, 4'hF,
            4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0};
    load();
    run("prog_basic", -1, bc, di);
    chk_int("basic_done_idx", di, 13);
    chk_int("basic_busy_cycles", bc, 14);

    // Writes and start while busy are ignored; rerun shows the same trace.
    run("inject_busy", 2, bc, di);
    run("rerun_after_inject", -1, bc, di);

    // Three-cycle opcode then HALT.
    img = '{4'h9, 4'hF, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0,
            4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0};
    load();
    run("prog_mult", -1, bc, di);
    chk_int("mult_busy_cycles", bc, 7);

    // No HALT: sixteen single-cycle instructions, then wrap ends the program.
    for (int a = 0; a < 16; a++) img[a] = 4'h3;
    load();
    run("prog_wrap16", -1, bc, di);
    chk_int("wrap16_busy_cycles", bc, 34);

    // Operand opcode at address 15 takes its operand from address 0.
    img[0] = 4'h7;
    for (int a = 1; a < 15; a++) img[a] = 4'h3;
    img[15] = 4'h1;
    load();
    run("prog_op15", -1, bc, di);

    // Reset during EXEC of a three-cycle opcode aborts without a done pulse.
    img = '{4'h9, 4'hF, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0,
            4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0};
    load();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    chk("abort_in_exec", 0, obs(), pk(1'b0, 1'b1, 1'b0, 4'h0));
    #2 rst = 1'b1;
    #1;
    chk("abort_async", 0, obs(), pk(1'b1, 1'b0, 1'b0, 4'h0));
    @(negedge clk);
    rst = 1'b0;
    chk("abort_held", 0, obs(), pk(1'b1, 1'b0, 1'b0, 4'h0));
    @(negedge clk);
    chk("abort_release", 0, obs(), pk(1'b0, 1'b0, 1'b0, 4'h0));
    run("replay_after_abort", -1, bc, di);

    // Random programs.
    for (int t = 0; t < 8; t++) begin
      for (int a = 0; a < 16; a++) img[a] = 4'($urandom_range(0, 15));
      load();
      run("random_prog", -1, bc, di);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
